// File: rtl/data_sramlike_wbuf_bridge_if.sv
// Sram-like data bus between the CPU data bridge (master) and the interconnect (slave).
interface data_sramlike_wbuf_bridge_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic [31:0]       data_rdata;
    logic              data_addr_ok;
    logic              data_data_ok;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_rdata, data_addr_ok, data_data_ok
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_rdata, data_addr_ok, data_data_ok
    );
endinterface

// File: rtl/data_sramlike_wbuf_bridge.sv
// CPU data-port bridge: sram-style CPU port to sram-like bus. Stores are posted into a
// FIFO write buffer that drains in the background; loads wait for a full drain, issue a
// single bus read and hold the result while the pipeline stays frozen.
module data_sramlike_wbuf_bridge #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WBUF_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cpu_en,
    input  logic [3:0]                    cpu_wen,
    input  logic [ADDR_W-1:0]             cpu_addr,
    input  logic [31:0]                   cpu_wdata,
    input  logic                          ext_stall,
    output logic [31:0]                   cpu_rdata,
    output logic                          cpu_stall,
    data_sramlike_wbuf_bridge_if.master   bus,
    output logic [$clog2(WBUF_DEPTH):0]   wbuf_count
);
    localparam int unsigned PTR_W = $clog2(WBUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_A    = 3'd1;
    localparam logic [2:0] WR_D    = 3'd2;
    localparam logic [2:0] RD_A    = 3'd3;
    localparam logic [2:0] RD_D    = 3'd4;
    localparam logic [2:0] RD_DONE = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              st_done_q, st_done_d;

    logic [ADDR_W-1:0] ent_addr_q  [WBUF_DEPTH];
    logic [31:0]       ent_wdata_q [WBUF_DEPTH];
    logic [1:0]        ent_size_q  [WBUF_DEPTH];

    logic is_store, is_load, full, push, pop;

    // One-hot strobe is a byte, an aligned pair a half, anything else a word (loads too).
    function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
        logic [1:0] size;
        case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 2'd0;
            4'b0011, 4'b1100:                   size = 2'd1;
            default:                            size = 2'd2;
        endcase
        return size;
    endfunction

    // Decode the CPU request and the FIFO push/pop strobes.
    always_comb begin
        is_store = cpu_en & (|cpu_wen);
        is_load  = cpu_en & ~(|cpu_wen);
        // Full is judged on the start-of-cycle count: a same-cycle pop does not free a slot.
        full     = (count_q == CNT_W'(WBUF_DEPTH));
        // st_done blocks a second push of a store that is held by ext_stall.
        push     = is_store & ~full & ~st_done_q;
        pop      = ((state_q == WR_A) & bus.data_addr_ok & bus.data_data_ok) |
                   ((state_q == WR_D) & bus.data_data_ok);
        cpu_stall = (is_store & full & ~st_done_q) | (is_load & (state_q != RD_DONE));
    end

    // FIFO pointer, occupancy and held-store bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        st_done_d = st_done_q;
        if (push && ext_stall) begin
            st_done_d = 1'b1;
        end else if (!ext_stall) begin
            st_done_d = 1'b0;
        end
    end

    // Transaction FSM: drain the write buffer first, then serve a pending load.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = WR_A;
                end else if (is_load) begin
                    state_d = RD_A;
                end
            end
            WR_A: begin
                if (bus.data_addr_ok) state_d = bus.data_data_ok ? IDLE : WR_D;
            end
            WR_D: begin
                if (bus.data_data_ok) state_d = IDLE;
            end
            RD_A: begin
                if (bus.data_addr_ok) begin
                    if (bus.data_data_ok) begin
                        rdata_d = bus.data_rdata;
                        state_d = RD_DONE;
                    end else begin
                        state_d = RD_D;
                    end
                end
            end
            RD_D: begin
                if (bus.data_data_ok) begin
                    rdata_d = bus.data_rdata;
                    state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                if (!ext_stall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are driven only in the address phases and are zero otherwise.
    always_comb begin
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_size  = 2'd0;
        bus.data_addr  = '0;
        bus.data_wdata = 32'd0;
        case (state_q)
            WR_A: begin
                bus.data_req   = 1'b1;
                bus.data_wr    = 1'b1;
                bus.data_size  = ent_size_q[rd_ptr_q];
                bus.data_addr  = ent_addr_q[rd_ptr_q];
                bus.data_wdata = ent_wdata_q[rd_ptr_q];
            end
            RD_A: begin
                bus.data_req  = 1'b1;
                bus.data_size = wen_to_size(cpu_wen);
                bus.data_addr = cpu_addr;
            end
            default: ;
        endcase
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rdata_q   <= 32'd0;
            st_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rdata_q   <= rdata_d;
            st_done_q <= st_done_d;
        end
    end

    // Buffer storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr_q[wr_ptr_q]  <= cpu_addr;
            ent_wdata_q[wr_ptr_q] <= cpu_wdata;
            ent_size_q[wr_ptr_q]  <= wen_to_size(cpu_wen);
        end
    end

    assign cpu_rdata  = rdata_q;
    assign wbuf_count = count_q;

endmodule
